// File: rtl/laserdrop_pkg.sv
// Shared types and defaults for the LaserDrop byte queues.
package laserdrop_pkg;

    localparam int unsigned BYTE_W_DEF     = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 64;

    typedef logic [BYTE_W_DEF-1:0] byte_t;

    // Width of a field that counts 0..n lanes.
    function automatic int unsigned lane_cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/laser_lane_fifo_if.sv
// Push/pop and status bundle of the multi-lane byte FIFO.
interface laser_lane_fifo_if #(
    parameter int unsigned BYTE_W   = laserdrop_pkg::BYTE_W_DEF,
    parameter int unsigned DEPTH    = laserdrop_pkg::FIFO_DEPTH_DEF,
    parameter int unsigned IN_LANES = 2
);
    import laserdrop_pkg::*;

    localparam int unsigned CntW  = lane_cnt_w(IN_LANES);
    localparam int unsigned SizeW = $clog2(DEPTH + 1);

    logic                         clear;
    logic [IN_LANES*BYTE_W-1:0]   D;
    logic                         load;
    logic [CntW-1:0]              load_cnt;
    logic                         read;
    logic [BYTE_W-1:0]            Q;
    logic [SizeW-1:0]             size;
    logic [SizeW-1:0]             free;
    logic                         empty;
    logic                         full;
    logic                         can_load;
    logic                         almost_full;
    logic                         overflow;
    logic                         underflow;

    modport master (
        output clear, D, load, load_cnt, read,
        input  Q, size, free, empty, full, can_load, almost_full, overflow, underflow
    );

    modport slave (
        input  clear, D, load, load_cnt, read,
        output Q, size, free, empty, full, can_load, almost_full, overflow, underflow
    );

endinterface

// File: rtl/laser_fifo_ctrl.sv
// Pointer/occupancy bookkeeping and push/pop acceptance for laser_lane_fifo.
module laser_fifo_ctrl #(
    parameter int unsigned DEPTH    = laserdrop_pkg::FIFO_DEPTH_DEF,
    parameter int unsigned IN_LANES = 2,
    localparam int unsigned CntW    = laserdrop_pkg::lane_cnt_w(IN_LANES),
    localparam int unsigned SizeW   = $clog2(DEPTH + 1),
    localparam int unsigned PtrW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [CntW-1:0]  load_cnt_i,
    input  logic             read_i,
    output logic             push_ok_o,
    output logic [PtrW-1:0]  wr_ptr_o,
    output logic [PtrW-1:0]  rd_ptr_o,
    output logic [SizeW-1:0] size_o,
    output logic [SizeW-1:0] free_o,
    output logic             overflow_o,
    output logic             underflow_o
);
    import laserdrop_pkg::*;

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [SizeW-1:0] size_q, size_d, free, cnt_ext;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             push_ok, pop_ok, push_bad;

    always_comb begin
        cnt_ext  = SizeW'(load_cnt_i);
        free     = SizeW'(DEPTH) - size_q;
        // All-or-nothing: the whole push must fit in the pre-edge free space.
        push_ok  = load_i && (load_cnt_i != '0) && (load_cnt_i <= CntW'(IN_LANES))
                   && (cnt_ext <= free);
        push_bad = load_i && (load_cnt_i != '0) && !push_ok;
        pop_ok   = read_i && (size_q != '0);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        size_d   = size_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            size_d   = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(load_cnt_i);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            size_d = size_q + (push_ok ? cnt_ext : '0) - (pop_ok ? SizeW'(1) : '0);
            ovf_d  = ovf_q | push_bad;
            unf_d  = unf_q | (read_i && !pop_ok);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            size_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            size_q   <= size_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign push_ok_o   = push_ok && !clear_i;
    assign wr_ptr_o    = wr_ptr_q;
    assign rd_ptr_o    = rd_ptr_q;
    assign size_o      = size_q;
    assign free_o      = free;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: rtl/laser_lane_fifo.sv
// Byte FIFO taking 1..IN_LANES bytes per push and draining one byte per pop.
module laser_lane_fifo #(
    parameter int unsigned BYTE_W    = laserdrop_pkg::BYTE_W_DEF,
    parameter int unsigned DEPTH     = laserdrop_pkg::FIFO_DEPTH_DEF,
    parameter int unsigned IN_LANES  = 2,
    parameter int unsigned AF_THRESH = DEPTH - 8
) (
    input  logic               clock,
    input  logic               reset,
    laser_lane_fifo_if.slave   bus
);
    import laserdrop_pkg::*;

    localparam int unsigned SizeW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW  = $clog2(DEPTH);

    logic [PtrW-1:0]   wr_ptr, rd_ptr;
    logic [SizeW-1:0]  size, free;
    logic              push_ok;
    logic [BYTE_W-1:0] mem_q [DEPTH];

    laser_fifo_ctrl #(
        .DEPTH    (DEPTH),
        .IN_LANES (IN_LANES)
    ) u_ctrl (
        .clk_i       (clock),
        .rst_i       (reset),
        .clear_i     (bus.clear),
        .load_i      (bus.load),
        .load_cnt_i  (bus.load_cnt),
        .read_i      (bus.read),
        .push_ok_o   (push_ok),
        .wr_ptr_o    (wr_ptr),
        .rd_ptr_o    (rd_ptr),
        .size_o      (size),
        .free_o      (free),
        .overflow_o  (bus.overflow),
        .underflow_o (bus.underflow)
    );

    // Storage is deliberately left unreset; lane addresses wrap modulo DEPTH.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            for (int unsigned i = 0; i < IN_LANES; i++) begin
                if (i < 32'(bus.load_cnt)) begin
                    mem_q[wr_ptr + PtrW'(i)] <= bus.D[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign bus.Q           = (size == '0) ? '0 : mem_q[rd_ptr];
    assign bus.size        = size;
    assign bus.free        = free;
    assign bus.empty       = (size == '0);
    assign bus.full        = (size == SizeW'(DEPTH));
    assign bus.can_load    = (free >= SizeW'(IN_LANES));
    assign bus.almost_full = (size >= SizeW'(AF_THRESH));

endmodule

// File: doc/laser_lane_fifo.md
Name: laser_lane_fifo

Overview:
- Parametrised byte FIFO; successor to the fixed 64-byte, 2-byte-push LaserDrop transmit and echo queues.
- Accepts 1..IN_LANES bytes per push, with a per-push valid-lane count, and drains one byte per pop.
- Adds all-or-nothing push acceptance, free-space and threshold flags, and sticky overflow/underflow error flags.
- Sits between the USB/FT-side byte source and the laser TX serializer; also serves as the echo buffer when IN_LANES=1.

Parameters:
- BYTE_W, 8, bits per entry.
- DEPTH, 64, number of entries; power of 2, at least 4.
- IN_LANES, 2, maximum bytes per push; 1..4; must not exceed DEPTH.
- AF_THRESH, DEPTH-8, almost_full asserts when size >= AF_THRESH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush.
- D  input  IN_LANES*BYTE_W  push data; lane 0 = D[BYTE_W-1:0] is oldest.
- load  input  1  push request.
- load_cnt  input  $clog2(IN_LANES+1)  valid lanes this push; lanes 0..load_cnt-1 are used.
- read  input  1  pop request.
- Q  output  BYTE_W  head byte.
- size  output  $clog2(DEPTH+1)  current occupancy.
- free  output  $clog2(DEPTH+1)  DEPTH-size.
- empty  output  1  size==0.
- full  output  1  size==DEPTH.
- can_load  output  1  free >= IN_LANES.
- almost_full  output  1  size >= AF_THRESH.
- overflow  output  1  sticky; a push was rejected.
- underflow  output  1  sticky; a pop was attempted while empty.

Behaviour:
- Reset (async, active-high): read/write pointers = 0, size = 0, overflow = underflow = 0.
  - Storage is not cleared.
  - Resulting outputs: Q = 0, empty = 1, full = 0, free = DEPTH, can_load = 1, almost_full = 0 (when AF_THRESH > 0).
- Reset asserted mid-stream discards all contents immediately.
- clear (synchronous): same effect as reset at the next edge.
  - Takes priority over load and read in that cycle; both are ignored and no error flags are set.
- Q is combinational from the head entry; latency from pop to the next byte on Q is 0.
  - Q is forced to 0 while empty.
- Push acceptance: push_ok = load && load_cnt != 0 && load_cnt <= IN_LANES && load_cnt <= free.
  - free is the pre-edge value.
  - The push is all-or-nothing; a partial write never occurs.
- Accepted push: lane i is written to mem[(wr_ptr+i) mod DEPTH] for i < load_cnt; wr_ptr += load_cnt (mod DEPTH).
- Rejected push (load=1, load_cnt != 0, push_ok=0): no state change; overflow <= 1.
- load with load_cnt==0: no-op, no flag.
- Pop acceptance: pop_ok = read && !empty, using pre-edge empty; rd_ptr += 1 (mod DEPTH).
- read while empty: no change; underflow <= 1.
- Simultaneous push and pop: both are evaluated against the pre-edge state.
  - size_next = size + (push_ok ? load_cnt : 0) - (pop_ok ? 1 : 0).
  - A pop in the same cycle does not create room for a push.
  - A byte pushed this cycle is not poppable this cycle.
- Pointer wrap: pointers are log2(DEPTH) bits; lane writes wrap across the DEPTH-1 to 0 boundary.
- size is held explicitly (not derived from pointers) so that full and empty are distinguishable.
- overflow and underflow clear only on reset or clear.
- All flags other than overflow/underflow are combinational from size.

Decomposition:
- Package laserdrop_pkg holds:
  - BYTE_W default;
  - the default FIFO depth;
  - function lane_cnt_w(n) = $clog2(n+1);
  - typedef byte_t = logic [BYTE_W-1:0].
- One sub-module, laser_fifo_ctrl: pointers, size, the push_ok/pop_ok decision, and the sticky flags.
- The top level instantiates laser_fifo_ctrl and owns the storage array and lane write decode.

Test Plan (defaults DEPTH=64, IN_LANES=2, AF_THRESH=56):
- Reset, then push D=16'hBBAA with load_cnt=2 → size=2, Q=8'hAA; pop → Q=8'hBB; pop → empty=1, Q=0.
- 31 pushes of cnt=2, then one push of cnt=1 (size 63, can_load=0), then a cnt=2 push → rejected, size stays 63, overflow=1; then a cnt=1 push → full=1, size=64.
- Wrap: push/pop streaming 200 bytes with values 0..199 mixing cnt 1 and 2 → output order exactly 0..199, size never exceeds DEPTH.
- At size=63, assert load (cnt=2) and read together → pop accepted, push rejected, size=62, overflow=1; at size=0 with load cnt=1 and read → size=1, underflow=1.
- Mid-stream (size=40), pulse clear with load=read=1 → size=0, empty=1, flags 0; same via async reset between edges → outputs reset before the next edge.
- Parameter sweep IN_LANES=4, DEPTH=8: push cnt=3 at wr_ptr=6 → bytes land at 6,7,0; AF_THRESH=6 → almost_full=1 at size 6.
